// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 test-system bus master.
//   bm_state_e : transfer sequencer states, in the order they are visited
//   RD_LEN     : clock cycles nRD is held low
//   WR_LEN     : clock cycles nWR is held low
package z80_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETUP,
    ST_READ,
    ST_WSETUP,
    ST_WRITE,
    ST_WHOLD
  } bm_state_e;

  localparam int RD_LEN     = 2;
  localparam int WR_LEN     = 2;
  localparam int STROBE_MAX = (RD_LEN > WR_LEN) ? RD_LEN : WR_LEN;

endpackage

// File: rtl/bus_master_if.sv
// Bus request/acknowledge handshake between a DMA-style master and the CPU.
//   nBUSRQ : bus request, active-low, driven by the master
//   nBUSAK : bus acknowledge, active-low, driven by the CPU
interface bus_master_if;
  logic nBUSRQ;
  logic nBUSAK;

  modport master (output nBUSRQ, input  nBUSAK);
  modport slave  (input  nBUSRQ, output nBUSAK);
endinterface

// File: rtl/bus_master.sv
// Autonomous bus master: every INTERVAL idle cycles it requests the CPU bus,
// and once granted performs a read-modify-write (byte += STEP) at XFER_ADDR.
//   clock : system clock, rising edge
//   nCLR  : asynchronous active-low reset
//   bus   : nBUSRQ out / nBUSAK in handshake (master modport)
//   nRD   : read strobe, active-low, tri-stated when bus not owned
//   nWR   : write strobe, active-low, tri-stated when bus not owned
//   ADDR  : address bus, tri-stated when bus not owned
//   DQ    : bidirectional data bus, driven only during the write phase
module bus_master
  import z80_bus_pkg::*;
#(
  parameter int          INTERVAL  = 40,
  parameter logic [15:0] XFER_ADDR = 16'h0012,
  parameter logic [7:0]  STEP      = 8'h01
) (
  input  logic         clock,
  input  logic         nCLR,
  bus_master_if.master bus,
  output wire          nRD,
  output wire          nWR,
  output wire  [15:0]  ADDR,
  inout  wire  [7:0]   DQ
);

  localparam int            CW     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int            PW     = (STROBE_MAX > 1) ? $clog2(STROBE_MAX) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(INTERVAL - 1);

  bm_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [PW-1:0] r_phase, w_phase_nxt;
  logic          w_capture;
  logic          w_granted;

  // Registered output stage
  logic          r_nbusrq;
  logic          r_bus_oe;   // ADDR / nRD / nWR drive enable
  logic          r_dq_oe;    // DQ drive enable
  logic          r_nrd;
  logic          r_nwr;
  logic [7:0]    r_data;     // byte to write back (read value + STEP)

  // ---------------------------------------------------------------------
  // Sequencer state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge nCLR) begin
    if (!nCLR) begin
      r_state <= ST_IDLE;
      r_cnt   <= RELOAD;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_capture   = 1'b0;
    w_granted   = (r_state != ST_IDLE) && (r_state != ST_REQ);

    case (r_state)
      ST_IDLE: begin
        if (r_cnt == '0) w_state_nxt = ST_REQ;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_REQ: begin
        if (!bus.nBUSAK) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_state_nxt = ST_READ;
        w_phase_nxt = '0;
      end
      ST_READ: begin
        if (r_phase == PW'(RD_LEN - 1)) begin
          w_state_nxt = ST_WSETUP;
          w_capture   = 1'b1;
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
      ST_WSETUP: begin
        w_state_nxt = ST_WRITE;
        w_phase_nxt = '0;
      end
      ST_WRITE: begin
        if (r_phase == PW'(WR_LEN - 1)) w_state_nxt = ST_WHOLD;
        else                            w_phase_nxt = r_phase + 1'b1;
      end
      ST_WHOLD: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    // Losing the grant while we own the bus drops straight back to idle.
    if (w_granted && bus.nBUSAK) begin
      w_state_nxt = ST_IDLE;
      w_capture   = 1'b0;
    end

    // Every return to idle restarts the full interval.
    if ((w_state_nxt == ST_IDLE) && (r_state != ST_IDLE)) w_cnt_nxt = RELOAD;
  end

  // ---------------------------------------------------------------------
  // Output registers: decoded from the next state so each pin changes
  // cleanly on the edge that enters the state, with no path from nBUSAK
  // to a pin other than through a flop.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge nCLR) begin
    if (!nCLR) begin
      r_nbusrq <= 1'b1;
      r_bus_oe <= 1'b0;
      r_dq_oe  <= 1'b0;
      r_nrd    <= 1'b1;
      r_nwr    <= 1'b1;
      r_data   <= '0;
    end else begin
      r_nbusrq <= (w_state_nxt == ST_IDLE);
      r_bus_oe <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_REQ);
      r_dq_oe  <= (w_state_nxt == ST_WSETUP) || (w_state_nxt == ST_WRITE) ||
                  (w_state_nxt == ST_WHOLD);
      r_nrd    <= (w_state_nxt != ST_READ);
      r_nwr    <= (w_state_nxt != ST_WRITE);
      // Sum is formed at capture so DQ is driven straight from a flop.
      if (w_capture) r_data <= DQ + STEP;
    end
  end

  // ---------------------------------------------------------------------
  // Tri-state output stage
  // ---------------------------------------------------------------------
  assign bus.nBUSRQ = r_nbusrq;
  assign ADDR       = r_bus_oe ? XFER_ADDR : 16'hzzzz;
  assign nRD        = r_bus_oe ? r_nrd     : 1'bz;
  assign nWR        = r_bus_oe ? r_nwr     : 1'bz;
  assign DQ         = r_dq_oe  ? r_data    : 8'hzz;

endmodule

// File: tb/tb_bus_master.sv
// Testbench for bus_master: 4K RAM model on the shared bus, CPU grant model,
// scoreboard of expected write-back bytes checked by an independent monitor.
module tb_bus_master;
  import z80_bus_pkg::*;

  localparam int          INTERVAL = 40;
  localparam logic [15:0] XADDR    = 16'h0012;
  localparam logic [7:0]  STEP     = 8'h01;

  logic clock = 1'b0;
  logic nCLR  = 1'b1;
  wire        nRD, nWR;
  wire [15:0] ADDR;
  wire [7:0]  DQ;

  bus_master_if bif();

  pullup (nRD);
  pullup (nWR);

  bus_master #(.INTERVAL(INTERVAL), .XFER_ADDR(XADDR), .STEP(STEP)) dut (
    .clock (clock),
    .nCLR  (nCLR),
    .bus   (bif),
    .nRD   (nRD),
    .nWR   (nWR),
    .ADDR  (ADDR),
    .DQ    (DQ)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always_ff @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- RAM model ----------------
  logic [7:0] ram [0:4095];
  logic       pl_en   = 1'b0;
  logic [7:0] pl_data = 8'h00;

  always_ff @(posedge clock) begin
    if (pl_en)            ram[XADDR[11:0]] <= pl_data;
    else if (nWR == 1'b0) ram[ADDR[11:0]]  <= DQ;
  end
  assign DQ = (nRD == 1'b0) ? ram[ADDR[11:0]] : 8'hzz;

  // ---------------- CPU grant model: ack follows request one cycle late ----
  logic ack_en = 1'b0;
  logic rq_d1  = 1'b1;
  logic rq_d2  = 1'b1;
  assign bif.nBUSAK = ack_en ? rq_d2 : 1'b1;

  initial forever begin
    @(posedge clock);
    #1;
    rq_d2 = rq_d1;
    rq_d1 = bif.nBUSRQ;
  end

  // ---------------- Reference model / scoreboard ----------------
  logic [7:0] model;
  logic [7:0] sb_q [$];
  logic       cut_short = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_xfer();
    model = model + STEP;
    sb_q.push_back(model);
  endtask

  task automatic preload(input logic [7:0] v);
    pl_data = v;
    pl_en   = 1'b1;
    @(negedge clock);
    pl_en   = 1'b0;
    model   = v;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bif.nBUSRQ;
      1:       return nRD;
      default: return nWR;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic lvl, input int maxc, input string name);
    int n;
    n = 0;
    while (sig(which) !== lvl && n < maxc) begin
      @(negedge clock);
      n++;
    end
    if (sig(which) !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: timed out after %0d cycles", name, maxc);
    end
  endtask

  task automatic chk_released(input string tag);
    chk({tag, "_nbusrq"}, bif.nBUSRQ, 1'b1);
    chk({tag, "_nrd"},    nRD,        1'b1);
    chk({tag, "_nwr"},    nWR,        1'b1);
    chk({tag, "_bus_oe"}, dut.r_bus_oe, 1'b0);
    chk({tag, "_dq_oe"},  dut.r_dq_oe,  1'b0);
  endtask

  // ---------------- Monitor ----------------
  initial begin
    int          rd_len, wr_len;
    int unsigned rd_start;
    logic [7:0]  e;
    rd_len = 0; wr_len = 0; rd_start = 0;
    forever begin
      @(negedge clock);
      if (!nCLR) begin
        rd_len = 0;
        wr_len = 0;
      end else begin
        if (nRD === 1'b0) begin
          if (rd_len == 0) begin
            rd_start = cyc;
            chk("rd_addr", ADDR, XADDR);
          end
          rd_len++;
        end else if (rd_len != 0) begin
          if (!cut_short) chk("rd_len", rd_len, RD_LEN);
          rd_len = 0;
        end
        if (nWR === 1'b0) begin
          if (wr_len == 0) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_write: data %0h with no transfer expected", DQ);
            end else begin
              e = sb_q.pop_front();
              chk("wr_data", DQ, e);
              chk("wr_addr", ADDR, XADDR);
              if (!cut_short) chk("rd_to_wr", cyc - rd_start, 3);
            end
          end
          wr_len++;
        end else if (wr_len != 0) begin
          if (!cut_short) chk("wr_len", wr_len, WR_LEN);
          wr_len = 0;
        end
      end
    end
  end

  // ---------------- Watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- Stimulus ----------------
  initial begin
    int          n, n_oe, bad;
    int unsigned c0;
    logic [7:0]  v;

    nCLR = 1'b0;
    repeat (3) @(negedge clock);
    preload(8'h05);
    chk_released("rst");

    // Normal transfer with first-request timing
    ack_en = 1'b1;
    expect_xfer();
    @(negedge clock);
    nCLR = 1'b1;
    c0 = cyc;
    wait_for(0, 1'b0, 100, "first_rq");
    chk("first_rq_delay", cyc - c0, INTERVAL);
    n = 0; n_oe = 0;
    while (bif.nBUSRQ === 1'b0 && n < 60) begin
      @(negedge clock);
      n++;
      if (dut.r_bus_oe) n_oe++;
    end
    chk("rq_low_cycles", n, 9);
    chk("own_cycles", n_oe, 7);
    chk("ram_normal", ram[XADDR[11:0]], 8'h06);
    chk_released("post");

    // Back-to-back interval
    c0 = cyc;
    expect_xfer();
    wait_for(0, 1'b0, 100, "b2b_rq");
    chk("b2b_interval", cyc - c0, INTERVAL);
    wait_for(0, 1'b1, 30, "b2b_rel");
    chk("ram_b2b", ram[XADDR[11:0]], model);

    // Wrap: FF -> 00 -> 01
    preload(8'hFF);
    expect_xfer();
    expect_xfer();
    wait_for(0, 1'b0, 100, "wrap1_rq");
    wait_for(0, 1'b1, 30, "wrap1_rel");
    chk("ram_wrap0", ram[XADDR[11:0]], 8'h00);
    wait_for(0, 1'b0, 100, "wrap2_rq");
    wait_for(0, 1'b1, 30, "wrap2_rel");
    chk("ram_wrap1", ram[XADDR[11:0]], 8'h01);

    // Random starting bytes
    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom);
      preload(v);
      expect_xfer();
      wait_for(0, 1'b0, 100, "rand_rq");
      wait_for(0, 1'b1, 30, "rand_rel");
      chk("ram_rand", ram[XADDR[11:0]], model);
    end

    // No grant: request held, bus untouched
    ack_en = 1'b0;
    wait_for(0, 1'b0, 100, "nogrant_rq");
    bad = 0;
    repeat (60) begin
      @(negedge clock);
      if (bif.nBUSRQ !== 1'b0 || nRD !== 1'b1 || nWR !== 1'b1 ||
          dut.r_bus_oe || dut.r_dq_oe) bad++;
    end
    chk("nogrant_hold", bad, 0);

    // Abort during READ
    ack_en = 1'b1;
    wait_for(1, 1'b0, 10, "abort_rd");
    cut_short = 1'b1;
    ack_en    = 1'b0;
    @(negedge clock);
    chk_released("abort");
    c0 = cyc;
    chk("ram_abort", ram[XADDR[11:0]], model);
    wait_for(0, 1'b0, 100, "abort_rerq");
    chk("abort_interval", cyc - c0, INTERVAL);
    cut_short = 1'b0;
    expect_xfer();
    ack_en = 1'b1;
    wait_for(0, 1'b1, 30, "abort_rel");
    chk("ram_after_abort", ram[XADDR[11:0]], model);

    // Reset asserted mid-WRITE
    expect_xfer();
    cut_short = 1'b1;
    wait_for(2, 1'b0, 100, "rm_wr");
    @(posedge clock);
    #2;
    nCLR = 1'b0;
    #1;
    chk_released("rstmid");
    @(negedge clock);
    chk("ram_rstmid", ram[XADDR[11:0]], model);
    nCLR = 1'b1;
    cut_short = 1'b0;
    @(negedge clock);
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
